// File: rtl/updown_counter_arbiter.sv
// updown_counter_arbiter
//
// Purpose:
//   Two control agents share one 4-bit up/down wrapping counter. Each agent
//   asks for a burst of 1-16 steps in a chosen direction. The block grants
//   one agent at a time with round-robin on ties. It then steps the counter
//   once per clock for the whole burst and finally pulses done.
//
// Ports:
//   clk    in   1  clock, all state changes on the rising edge
//   rst    in   1  synchronous active-high reset
//   req    in   2  per-requester burst request (level), bit i = requester i
//   up_in  in   2  per-requester direction, 1 = up, 0 = down
//   len0   in   4  requester 0 burst length field L (steps = L+1)
//   len1   in   4  requester 1 burst length field L (steps = L+1)
//   clr    in   1  counter clear, honoured only while idle, beats req
//   gnt    out  2  one-hot, one-cycle grant acknowledge
//   owner  out  1  requester currently or most recently granted
//   busy   out  1  high while a burst is running or completing
//   q      out  4  counter value
//   wrap   out  1  one-cycle pulse, the previous step wrapped
//   done   out  1  one-cycle pulse, burst complete and q is final

module updown_counter_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] up_in,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic       clr,
  output logic [1:0] gnt,
  output logic       owner,
  output logic       busy,
  output logic [3:0] q,
  output logic       wrap,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] rem_q, rem_d;
  logic       dir_q, dir_d;
  logic       owner_q, owner_d;
  logic       lastOwner_q, lastOwner_d;
  logic [1:0] gnt_q, gnt_d;
  logic       done_q, done_d;
  logic       wrap_q, wrap_d;
  logic       busy_q, busy_d;

  logic       winner;
  logic [3:0] countStep;

  // Arbitration. A lone requester always wins. On a tie the requester
  // that did not finish the previous burst wins. last owner resets to 1 so
  // requester 0 takes the first tie.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = ~lastOwner_q;
    end
  end

  // One step of the counter in the latched direction. 4-bit arithmetic
  // gives the modulo-16 wrap for free.
  always_comb begin
    countStep = dir_q ? (count_q + 4'd1) : (count_q - 4'd1);
  end

  // Register bank. Every output comes straight from a flop here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 4'd0;
      rem_q       <= 4'd0;
      dir_q       <= 1'b0;
      owner_q     <= 1'b0;
      lastOwner_q <= 1'b1;
      gnt_q       <= 2'b00;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      dir_q       <= dir_d;
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic. gnt, done and wrap default low, so each one is a
  // single-cycle pulse. rem counts the steps still owed after the current
  // step, so the step taken with rem==0 is the last one.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    gnt_d       = 2'b00;
    done_d      = 1'b0;
    wrap_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (clr) begin
          count_d = 4'd0;
        end else if (req != 2'b00) begin
          dir_d   = up_in[winner];
          rem_d   = winner ? len1 : len0;
          owner_d = winner;
          gnt_d   = winner ? 2'b10 : 2'b01;
          state_d = RUN;
        end
      end
      RUN: begin
        count_d = countStep;
        wrap_d  = dir_q ? (count_q == 4'hF) : (count_q == 4'h0);
        if (rem_q == 4'd0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          rem_d = rem_q - 4'd1;
        end
      end
      DONE: begin
        lastOwner_d = owner_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign q     = count_q;
  assign wrap  = wrap_q;
  assign done  = done_q;

endmodule

// File: tb/tb_updown_counter_arbiter.sv
// tb_updown_counter_arbiter
//
// Purpose:
//   Directed bench for updown_counter_arbiter. Inputs change on the falling
//   edge and outputs are sampled on the falling edge, half a cycle after the
//   rising edge that updated them. Expected values are worked out by hand or
//   computed locally from the burst start value and direction.

module tb_updown_counter_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] up_in;
  logic [3:0] len0;
  logic [3:0] len1;
  logic       clr;
  logic [1:0] gnt;
  logic       owner;
  logic       busy;
  logic [3:0] q;
  logic       wrap;
  logic       done;

  int checks = 0;
  int errors = 0;

  updown_counter_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .up_in (up_in),
    .len0  (len0),
    .len1  (len1),
    .clr   (clr),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .q     (q),
    .wrap  (wrap),
    .done  (done)
  );

  // 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive every request-side input at once.
  task automatic applyStimulus(input logic [1:0] reqV, input logic [1:0] upV,
                               input logic [3:0] l0, input logic [3:0] l1,
                               input logic clrV);
    req   = reqV;
    up_in = upV;
    len0  = l0;
    len1  = l1;
    clr   = clrV;
  endtask

  // Advance one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] expQ;
    int         wrapCount;
    logic [1:0] rrGnt [4];

    rrGnt[0] = 2'b01;
    rrGnt[1] = 2'b10;
    rrGnt[2] = 2'b01;
    rrGnt[3] = 2'b10;

    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    tick();
    tick();

    // Reset state
    checkOutput("rst_q", q, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wrap", wrap, 0);
    checkOutput("rst_owner", owner, 0);

    // Single up burst of 4 steps from 0
    $display("[TB] single up burst");
    rst = 1'b0;
    applyStimulus(2'b01, 2'b01, 4'd3, 4'd0, 1'b0);
    tick();
    checkOutput("up_gnt", gnt, 2'b01);
    checkOutput("up_busy", busy, 1);
    checkOutput("up_q_at_gnt", q, 0);
    checkOutput("up_owner", owner, 0);
    req = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("up_q", q, i);
      checkOutput("up_wrap", wrap, 0);
      checkOutput("up_done", done, (i == 4) ? 1 : 0);
      checkOutput("up_gnt_low", gnt, 0);
      checkOutput("up_busy_run", busy, 1);
    end
    tick();
    checkOutput("up_busy_end", busy, 0);
    checkOutput("up_done_end", done, 0);
    checkOutput("up_q_hold", q, 4);

    // Clear back to 0, then down burst of 2 steps with a wrap
    $display("[TB] down wrap");
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 1'b1);
    tick();
    checkOutput("clr_q", q, 0);
    applyStimulus(2'b10, 2'b00, 4'd0, 4'd1, 1'b0);
    tick();
    checkOutput("dn_gnt", gnt, 2'b10);
    checkOutput("dn_owner", owner, 1);
    req = 2'b00;
    tick();
    checkOutput("dn_q1", q, 15);
    checkOutput("dn_wrap1", wrap, 1);
    checkOutput("dn_done1", done, 0);
    tick();
    checkOutput("dn_q2", q, 14);
    checkOutput("dn_wrap2", wrap, 0);
    checkOutput("dn_done2", done, 1);
    tick();
    checkOutput("dn_busy_end", busy, 0);

    // clr beats req in IDLE and is ignored during RUN
    $display("[TB] clr priority");
    applyStimulus(2'b01, 2'b01, 4'd2, 4'd0, 1'b1);
    tick();
    checkOutput("clr_pri_q", q, 0);
    checkOutput("clr_pri_gnt", gnt, 0);
    checkOutput("clr_pri_busy", busy, 0);
    clr = 1'b0;
    tick();
    checkOutput("clr_gnt", gnt, 2'b01);
    req = 2'b00;
    clr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("clr_run_q", q, i);
    end
    checkOutput("clr_run_done", done, 1);
    clr = 1'b0;
    tick();
    checkOutput("clr_busy_end", busy, 0);

    // Bring q from 3 to 7, then a 16-step full burst from 7
    $display("[TB] full-length burst");
    applyStimulus(2'b01, 2'b01, 4'd3, 4'd0, 1'b0);
    tick();
    req = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("pre_full_q", q, 7);
    checkOutput("pre_full_busy", busy, 0);
    applyStimulus(2'b01, 2'b01, 4'd15, 4'd0, 1'b0);
    tick();
    checkOutput("full_gnt", gnt, 2'b01);
    req = 2'b00;
    expQ = 4'd7;
    wrapCount = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      expQ = expQ + 4'd1;
      checkOutput("full_q", q, expQ);
      checkOutput("full_wrap", wrap, (expQ == 4'd0) ? 1 : 0);
      checkOutput("full_done", done, (i == 16) ? 1 : 0);
      if (wrap === 1'b1) wrapCount++;
    end
    checkOutput("full_wrap_count", wrapCount, 1);
    checkOutput("full_q_final", q, 7);
    tick();
    checkOutput("full_busy_end", busy, 0);

    // Reset in the third RUN cycle of a 10-step burst by requester 1
    $display("[TB] reset mid-burst");
    applyStimulus(2'b10, 2'b10, 4'd0, 4'd9, 1'b0);
    tick();
    checkOutput("mid_gnt", gnt, 2'b10);
    req = 2'b00;
    tick();
    checkOutput("mid_q1", q, 8);
    tick();
    checkOutput("mid_q2", q, 9);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_q", q, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_owner", owner, 0);
    checkOutput("mid_rst_done", done, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput("mid_no_done", done, 0);
      checkOutput("mid_idle_busy", busy, 0);
    end

    // Round-robin with both requesting: first tie goes to requester 0
    $display("[TB] round robin");
    applyStimulus(2'b11, 2'b11, 4'd0, 4'd0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      tick();
      checkOutput("rr_gnt", gnt, rrGnt[b]);
      checkOutput("rr_owner", owner, (rrGnt[b] == 2'b10) ? 1 : 0);
      tick();
      checkOutput("rr_q", q, b + 1);
      checkOutput("rr_done", done, 1);
      checkOutput("rr_gnt_low", gnt, 0);
      tick();
      checkOutput("rr_idle_busy", busy, 0);
      checkOutput("rr_idle_gnt", gnt, 0);
    end
    req = 2'b00;
    tick();
    checkOutput("rr_stop_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
